// File: rtl/exc_pkg.sv
// exc_pkg: exception cause codes, vector offsets and FSM/select enums shared by the exception unit.
package exc_pkg;
    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_MOD  = 5'd1;
    localparam logic [4:0] EX_TLBL = 5'd2;
    localparam logic [4:0] EX_TLBS = 5'd3;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;
    localparam logic [4:0] EX_TR   = 5'd13;
    localparam logic [11:0] VEC_REFILL  = 12'h000;
    localparam logic [11:0] VEC_GENERAL = 12'h180;
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;
    typedef enum logic [1:0] {BAD_NONE, BAD_INST, BAD_DATA} bad_sel_e;
endpackage

// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: commit-point sources in, CP0 writes and fetch redirect out.
interface exception_ctrl_if #(
    parameter int INT_LINES  = 8,
    parameter int EXC_CODE_W = 5
);
    logic [INT_LINES-1:0]  int_pending;
    logic [INT_LINES-1:0]  int_mask;
    logic                  int_enable;
    logic                  exl_in;
    logic                  bev;
    logic [19:0]           ebase;
    logic                  inst_miss, inst_invalid, inst_illegal;
    logic                  data_miss, data_invalid, data_dirty, data_illegal;
    logic                  data_we;
    logic                  syscall, brk, trap, unknown_inst, overflow, eret;
    logic                  commit_valid;
    logic                  in_delayslot;
    logic [31:0]           commit_pc, data_vaddr, epc_in;
    logic                  fetch_outstanding;
    logic                  exc_now;
    logic                  flush;
    logic                  wr_exp, badvaddr_we, clear_exl;
    logic [EXC_CODE_W-1:0] exp_code;
    logic [31:0]           epc;
    logic                  bd;
    logic [31:0]           badvaddr;
    logic [31:0]           new_pc;
    modport master (
        output int_pending, int_mask, int_enable, exl_in, bev, ebase,
               inst_miss, inst_invalid, inst_illegal,
               data_miss, data_invalid, data_dirty, data_illegal, data_we,
               syscall, brk, trap, unknown_inst, overflow, eret,
               commit_valid, in_delayslot, commit_pc, data_vaddr, epc_in, fetch_outstanding,
        input  exc_now, flush, wr_exp, badvaddr_we, clear_exl, exp_code, epc, bd, badvaddr, new_pc
    );
    modport slave (
        input  int_pending, int_mask, int_enable, exl_in, bev, ebase,
               inst_miss, inst_invalid, inst_illegal,
               data_miss, data_invalid, data_dirty, data_illegal, data_we,
               syscall, brk, trap, unknown_inst, overflow, eret,
               commit_valid, in_delayslot, commit_pc, data_vaddr, epc_in, fetch_outstanding,
        output exc_now, flush, wr_exp, badvaddr_we, clear_exl, exp_code, epc, bd, badvaddr, new_pc
    );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority pending event and its code, vector and BadVAddr source.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       int_hit_i,
    input  logic       commit_valid_i,
    input  logic       data_we_i,
    input  logic       inst_miss_i,
    input  logic       inst_invalid_i,
    input  logic       inst_illegal_i,
    input  logic       data_miss_i,
    input  logic       data_invalid_i,
    input  logic       data_dirty_i,
    input  logic       data_illegal_i,
    input  logic       syscall_i,
    input  logic       brk_i,
    input  logic       trap_i,
    input  logic       unknown_inst_i,
    input  logic       overflow_i,
    input  logic       eret_i,
    output logic       exc_hit_o,
    output logic [4:0] code_o,
    output logic       refill_o,
    output bad_sel_e   bad_sel_o,
    output logic       is_eret_o
);
    logic [4:0] tlb_code, adr_code;
    assign tlb_code = data_we_i ? EX_TLBS : EX_TLBL;
    assign adr_code = data_we_i ? EX_ADES : EX_ADEL;
    // Interrupts bypass commit_valid: a bubble still carries the resume PC.
    always_comb begin
        exc_hit_o = 1'b1;
        code_o    = EX_INT;
        refill_o  = 1'b0;
        bad_sel_o = BAD_NONE;
        is_eret_o = 1'b0;
        if (int_hit_i) code_o = EX_INT;
        else if (!commit_valid_i) exc_hit_o = 1'b0;
        else if (data_dirty_i && data_we_i) begin code_o = EX_MOD; bad_sel_o = BAD_DATA; end
        else if (inst_miss_i) begin code_o = EX_TLBL; refill_o = 1'b1; bad_sel_o = BAD_INST; end
        else if (data_miss_i) begin code_o = tlb_code; refill_o = 1'b1; bad_sel_o = BAD_DATA; end
        else if (inst_invalid_i) begin code_o = EX_TLBL; bad_sel_o = BAD_INST; end
        else if (data_invalid_i) begin code_o = tlb_code; bad_sel_o = BAD_DATA; end
        else if (inst_illegal_i) begin code_o = EX_ADEL; bad_sel_o = BAD_INST; end
        else if (data_illegal_i) begin code_o = adr_code; bad_sel_o = BAD_DATA; end
        else if (syscall_i) code_o = EX_SYS;
        else if (brk_i) code_o = EX_BP;
        else if (trap_i) code_o = EX_TR;
        else if (unknown_inst_i) code_o = EX_RI;
        else if (overflow_i) code_o = EX_OV;
        else if (eret_i) is_eret_o = 1'b1;
        else exc_hit_o = 1'b0;
    end
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: commit-point exception arbiter; registers CP0 updates and holds flush until fetch drains.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int          INT_LINES  = 8,
    parameter logic [31:0] RESET_BASE = 32'hBFC00200,
    parameter int          EXC_CODE_W = 5
) (
    input logic              clk,
    input logic              resetn,
    exception_ctrl_if.slave  bus
);
    state_e                state_q, state_d;
    logic [INT_LINES-1:0]  int_req;
    logic                  exc_hit, refill, is_eret, exc_now;
    logic [4:0]            code;
    bad_sel_e              bad_sel;
    logic [31:0]           vec_base;
    logic [11:0]           vec_off;
    logic                  wr_exp_q, badvaddr_we_q, clear_exl_q, bd_q;
    logic [EXC_CODE_W-1:0] exp_code_q;
    logic [31:0]           epc_q, badvaddr_q, new_pc_q;
    assign int_req = bus.int_pending & bus.int_mask;
    exc_prio_enc u_enc (
        .int_hit_i      (|int_req && bus.int_enable),
        .commit_valid_i (bus.commit_valid),
        .data_we_i      (bus.data_we),
        .inst_miss_i    (bus.inst_miss),
        .inst_invalid_i (bus.inst_invalid),
        .inst_illegal_i (bus.inst_illegal),
        .data_miss_i    (bus.data_miss),
        .data_invalid_i (bus.data_invalid),
        .data_dirty_i   (bus.data_dirty),
        .data_illegal_i (bus.data_illegal),
        .syscall_i      (bus.syscall),
        .brk_i          (bus.brk),
        .trap_i         (bus.trap),
        .unknown_inst_i (bus.unknown_inst),
        .overflow_i     (bus.overflow),
        .eret_i         (bus.eret),
        .exc_hit_o      (exc_hit),
        .code_o         (code),
        .refill_o       (refill),
        .bad_sel_o      (bad_sel),
        .is_eret_o      (is_eret)
    );
    // Sources seen while flushing belong to squashed instructions.
    assign exc_now  = exc_hit && (state_q == IDLE);
    assign vec_base = bus.bev ? RESET_BASE : {bus.ebase, 12'h000};
    assign vec_off  = (refill && !bus.exl_in) ? VEC_REFILL : VEC_GENERAL;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (exc_now ? REDIRECT : IDLE)
                                    : (bus.fetch_outstanding ? DRAIN : IDLE);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_exp_q      <= 1'b0;
            badvaddr_we_q <= 1'b0;
            clear_exl_q   <= 1'b0;
            bd_q          <= 1'b0;
            exp_code_q    <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            new_pc_q      <= '0;
        end else begin
            wr_exp_q      <= exc_now && !is_eret;
            clear_exl_q   <= exc_now && is_eret;
            badvaddr_we_q <= exc_now && (bad_sel != BAD_NONE);
            if (exc_now) begin
                new_pc_q <= is_eret ? bus.epc_in : vec_base + {20'h0, vec_off};
                if (!is_eret) exp_code_q <= EXC_CODE_W'(code);
                // A nested exception keeps the EPC of the original one.
                if (!is_eret && !bus.exl_in) begin
                    epc_q <= bus.in_delayslot ? bus.commit_pc - 32'd4 : bus.commit_pc;
                    bd_q  <= bus.in_delayslot;
                end
                if (bad_sel != BAD_NONE) badvaddr_q <= (bad_sel == BAD_INST) ? bus.commit_pc : bus.data_vaddr;
            end
        end
    end
    assign bus.exc_now     = exc_now;
    assign bus.flush       = (state_q != IDLE);
    assign bus.wr_exp      = wr_exp_q;
    assign bus.badvaddr_we = badvaddr_we_q;
    assign bus.clear_exl   = clear_exl_q;
    assign bus.exp_code    = exp_code_q;
    assign bus.epc         = epc_q;
    assign bus.bd          = bd_q;
    assign bus.badvaddr    = badvaddr_q;
    assign bus.new_pc      = new_pc_q;
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Parametrised successor to the pipeline exception unit: a single arbiter that samples all fault, trap and interrupt sources at the commit point, selects the highest-priority cause, and redirects fetch. Adds a configurable interrupt line count, EBase/BEV vector selection, EXL-aware TLB-refill vectoring, delay-slot EPC/BD generation, a Trap cause, and a fetch-drain handshake that holds flush until in-flight fetches retire. Sits between the memory-stage commit logic and the CP0 register file / fetch PC mux.

## Interface
- INT_LINES, 8, number of interrupt request lines (1..32)
- RESET_BASE, 32'hBFC00200, vector base when bev=1
- EXC_CODE_W, 5, width of exp_code

- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- int_pending  in  INT_LINES  raw interrupt requests (Cause.IP)
- int_mask  in  INT_LINES  Status.IM
- int_enable  in  1  Status.IE & !Status.EXL & !Status.ERL
- exl_in  in  1  current Status.EXL
- bev  in  1  Status.BEV
- ebase  in  20  EBase[31:12]
- inst_miss, inst_invalid, inst_illegal  in  1 each  fetch-side faults of committing instruction
- data_miss, data_invalid, data_dirty, data_illegal  in  1 each  data-side faults
- data_we  in  1  committing access is a store
- syscall, brk, trap, unknown_inst, overflow, eret  in  1 each  instruction-raised events
- commit_valid  in  1  committing slot holds a real instruction; all sources except interrupts ignored when 0
- in_delayslot  in  1  committing instruction is in a branch delay slot
- commit_pc, data_vaddr, epc_in  in  32 each  committing PC, data address, CP0.EPC
- fetch_outstanding  in  1  fetch has an un-retired request (icache miss or uncached in flight)
- exc_now  out  1  combinational: an event is taken this cycle
- flush  out  1  flush pipeline, fetch redirected to new_pc
- wr_exp, badvaddr_we, clear_exl  out  1 each  one-cycle CP0 write strobes
- exp_code  out  EXC_CODE_W  ExcCode
- epc  out  32  EPC value; bd  out  1  Cause.BD value
- badvaddr  out  32  BadVAddr value
- new_pc  out  32  redirect target

## Operation
- Priority (high→low): interrupt ((int_pending & int_mask)≠0 & int_enable), TLB Mod (data_dirty & data_we), inst_miss, data_miss, inst_invalid, data_invalid, inst_illegal, data_illegal, syscall, brk, trap, unknown_inst, overflow, eret.
- Codes: INT 0, MOD 1, TLBL 2, TLBS 3, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12, TR 13. Data faults use TLBS/ADES when data_we=1, else TLBL/ADEL.
- Base = bev ? RESET_BASE : {ebase,12'h0}. Offset 0x000 for inst_miss/data_miss when exl_in=0; 0x180 otherwise (including refill with exl_in=1).
- epc = in_delayslot ? commit_pc−4 : commit_pc; bd = in_delayslot. Not written when exl_in=1 (wr_exp still pulses; CP0 keeps EPC).
- badvaddr: commit_pc for inst faults, data_vaddr for data faults; badvaddr_we=1 only for those.
- eret: new_pc=epc_in, clear_exl=1, wr_exp=0, exp_code unchanged.
- FSM: IDLE → REDIRECT on exc_now; REDIRECT → DRAIN if fetch_outstanding else IDLE; DRAIN → IDLE when fetch_outstanding=0. flush=1 in REDIRECT and DRAIN (Moore). exc_now forced 0 outside IDLE; sources then ignored (they belong to flushed instructions).

## Timing
- Event sampled at edge T (IDLE); at T+1 state=REDIRECT, all outputs registered and valid; strobes high for that one cycle only.
- Minimum flush width 1 cycle; flush drops the cycle after fetch_outstanding is sampled 0.
- new_pc, exp_code, epc, bd, badvaddr hold until next event.
- Reset: state IDLE; flush, wr_exp, badvaddr_we, clear_exl, bd = 0; exp_code, epc, badvaddr, new_pc = 0. Reset during DRAIN returns to IDLE immediately with flush=0.
- Interrupt with commit_valid=0 is still taken; epc = commit_pc (bubble carries next PC).

## Structure
- Package exc_pkg: EX_* code constants, VEC_REFILL=0x000, VEC_GENERAL=0x180, state enum {IDLE, REDIRECT, DRAIN}.
- Sub-module exc_prio_enc: combinational priority encoder producing exc_now, code, vector-offset select, badvaddr select.

## Test plan
- int_pending=8'h04, int_mask=8'h04, int_enable=1, bev=1 → T+1 flush=1, exp_code=0, new_pc=BFC00380, wr_exp pulse.
- inst_miss, bev=0, ebase=20'h80001, exl_in=0 → new_pc=80001000, code 2, badvaddr=commit_pc; repeat exl_in=1 → new_pc=80001180.
- overflow, in_delayslot=1, commit_pc=0x8000_0104 → epc=80000100, bd=1, code 12.
- inst_miss and overflow same cycle → code 2 only; data_miss+data_we → code 3.
- syscall with fetch_outstanding high 3 cycles after T+1 → flush held 4 cycles, second syscall during DRAIN ignored.
- eret, epc_in=0x8000_2000 → new_pc=80002000, clear_exl pulse, wr_exp=0; assert resetn low mid-DRAIN → flush=0 next cycle, FSM IDLE.
